// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Clear sequencer state: CLEAR zeroes storage after reset, RUN is normal use.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  // Number of entries addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Low bit index of field k in a packed vector of w-bit fields.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read/status bundle between the core pipeline and the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       wdata;
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic                    busy;
  logic                    wr_err;

  modport master (output we, waddr, wdata, raddr, input rdata, busy, wr_err);
  modport slave  (input we, waddr, wdata, raddr, output rdata, busy, wr_err);
endinterface

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks every entry writing zero, then hands over.
//
// state | meaning
// CLEAR | zeroing mem[cnt] each clock; external writes rejected
// RUN   | storage initialised; external writes accepted
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_we,
  output logic              busy,
  output logic              wr_err,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(depth_of(ADDR_W) - 1);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              wr_err_nxt;

  // State, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLEAR;
      cnt    <= '0;
      wr_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      wr_err <= wr_err_nxt;
    end
  end

  // Next state: leave CLEAR on the terminal count, not on counter overflow.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wr_err_nxt = wr_err;
    busy       = 1'b0;
    clr_we     = 1'b0;
    clr_addr   = cnt;
    if (state == CLEAR) begin
      busy    = 1'b1;
      clr_we  = 1'b1;
      cnt_nxt = cnt + ADDR_W'(1);
      if (cnt == LAST) state_nxt = RUN;
      if (ext_we) wr_err_nxt = 1'b1;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwiring, write bypass,
// optional registered reads and a post-reset clear of all entries.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit REG_READ = 1'b0
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ext_ok;
  logic [DATA_W-1:0] rd_val [NREAD];

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .ext_we   (bus.we),
    .busy     (bus.busy),
    .wr_err   (bus.wr_err),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // An external write lands only in RUN and never on a hardwired entry 0.
  assign ext_ok = bus.we && !bus.busy && !(ZERO_REG && bus.waddr == '0);

  // Storage write port; the clear sequencer takes priority, reset leaves contents alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we)      mem[clr_addr]  <= '0;
      else if (ext_ok) mem[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    localparam int ALO = slice_lo(k, ADDR_W);
    localparam int DLO = slice_lo(k, DATA_W);
    logic [ADDR_W-1:0] ra;
    assign ra = bus.raddr[ALO +: ADDR_W];

    // Read value: masked while clearing, zero on entry 0, else bypass or storage.
    always_comb begin
      rd_val[k] = mem[ra];
      if (bus.busy)                                  rd_val[k] = '0;
      else if (ZERO_REG && ra == '0)                 rd_val[k] = '0;
      else if (BYPASS && ext_ok && bus.waddr == ra)  rd_val[k] = bus.wdata;
    end

    if (REG_READ) begin : g_reg
      logic [DATA_W-1:0] rd_q;
      // One-cycle registered read data.
      always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_val[k];
      end
      assign bus.rdata[DLO +: DATA_W] = rd_q;
    end else begin : g_comb
      assign bus.rdata[DLO +: DATA_W] = rd_val[k];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  raddr = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // a: ZERO_REG=1 BYPASS=1 REG_READ=0
  // b: ZERO_REG=0 BYPASS=1 REG_READ=1
  // c: ZERO_REG=1 BYPASS=0 REG_READ=0
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_a ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_b ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_c ();

  assign bus_a.we = we;  assign bus_a.waddr = waddr;  assign bus_a.wdata = wdata;  assign bus_a.raddr = raddr;
  assign bus_b.we = we;  assign bus_b.waddr = waddr;  assign bus_b.wdata = wdata;  assign bus_b.raddr = raddr;
  assign bus_c.we = we;  assign bus_c.waddr = waddr;  assign bus_c.wdata = wdata;  assign bus_c.raddr = raddr;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_READ(1'b0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1'b0), .BYPASS(1'b1), .REG_READ(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b0), .REG_READ(1'b0))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
    logic [31:0] exp_c0;
    logic [31:0] exp_b0;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; counts negedge samples with busy high.
  task automatic wait_clear(output int n);
    n = 0;
    while (bus_a.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd7,  32'h00000001, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h00000001};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h00000001, 32'h0,        32'h00000001, 32'h00000001};
    vecs[8] = '{1'b1, 5'd31, 32'h00000011, 5'd30, 5'd31, 32'h0,        32'h00000011, 32'h0,        32'h0};

    // Initial reset and clear
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, bus_a.busy}, 32'd1);
    chk("rst_wr_err", {31'b0, bus_a.wr_err}, 32'd0);
    chk("rst_b_rdata", bus_b.rdata[31:0], 32'h0);
    wait_clear(n);
    chk("clear_len", n, 32'd32);

    // Every entry reads 0 on both ports after the clear
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      raddr = {5'(31 - i), 5'(i)};
      #1;
      chk("clr_a0", bus_a.rdata[31:0], 32'h0);
      chk("clr_a1", bus_a.rdata[63:32], 32'h0);
      @(posedge clk); #1;
      chk("clr_b0", bus_b.rdata[31:0], 32'h0);
    end

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("v%0d_a0", i), bus_a.rdata[31:0], vecs[i].exp_a0);
      chk($sformatf("v%0d_a1", i), bus_a.rdata[63:32], vecs[i].exp_a1);
      chk($sformatf("v%0d_c0", i), bus_c.rdata[31:0], vecs[i].exp_c0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_b0", i), bus_b.rdata[31:0], vecs[i].exp_b0);
    end
    @(negedge clk);
    we = 1'b0;
    chk("run_wr_err", {31'b0, bus_a.wr_err}, 32'd0);

    // Write attempted in the 10th cycle of a clear
    do_reset();
    raddr = {5'd7, 5'd5};
    #1;
    chk("busy_mask_a0", bus_a.rdata[31:0], 32'h0);
    chk("busy_mask_a1", bus_a.rdata[63:32], 32'h0);
    repeat (9) @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF0000;
    raddr = {5'd3, 5'd3};
    #1;
    chk("busy_nobypass", bus_a.rdata[31:0], 32'h0);
    @(posedge clk); #1;
    chk("wr_err_rise", {31'b0, bus_a.wr_err}, 32'd1);
    @(negedge clk);
    we = 1'b0;
    wait_clear(n);
    chk("clear_len_err", n, 32'd22);
    chk("wr_err_sticky", {31'b0, bus_a.wr_err}, 32'd1);
    raddr = {5'd3, 5'd3};
    #1;
    chk("e3_a0", bus_a.rdata[31:0], 32'h0);
    chk("e3_c0", bus_c.rdata[31:0], 32'h0);
    @(posedge clk); #1;
    chk("e3_b0", bus_b.rdata[31:0], 32'h0);

    // Write entry 31, then reset in the 20th cycle of the following clear
    @(negedge clk);
    we = 1'b1; waddr = 5'd31; wdata = 32'h00000011;
    @(negedge clk);
    we = 1'b0; raddr = {5'd31, 5'd31};
    #1;
    chk("e31_pre", bus_a.rdata[31:0], 32'h00000011);
    do_reset();
    chk("wr_err_clr", {31'b0, bus_a.wr_err}, 32'd0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_clear(n);
    chk("clear_len_restart", n, 32'd32);
    #1;
    chk("e31_a0", bus_a.rdata[31:0], 32'h0);
    chk("e31_a1", bus_a.rdata[63:32], 32'h0);
    chk("e31_c0", bus_c.rdata[31:0], 32'h0);
    @(posedge clk); #1;
    chk("e31_b0", bus_b.rdata[31:0], 32'h0);
    chk("final_wr_err", {31'b0, bus_a.wr_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the single-read dual-port CPU register file.
- Adds N read ports, optional x0 hardwiring, write-to-read bypass and selectable read latency (0 or 1).
- Adds a post-reset clear sequencer that zeroes every entry, because block-RAM contents cannot be reset.
- Sits between the picorv32 core's decode/writeback stages and storage.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, entry 0 reads as zero and ignores writes when 1.
- BYPASS, 1, a same-cycle write to the addressed entry is forwarded to the read data when 1.
- REG_READ, 0, read latency in clocks (0 = combinational, 1 = registered).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- busy  out  1  clear sequence in progress.
- wr_err  out  1  sticky flag: a write was attempted while busy.

Behaviour:
- Reset values (reset high at a clock edge):
  - busy=1, wr_err=0, clear counter=0.
  - Registered rdata=0 when REG_READ=1.
  - Memory contents are not touched by reset itself.
- Clear FSM, states CLEAR and RUN:
  - Reset forces CLEAR with counter=0.
  - In CLEAR, each clock writes 0 to mem[counter], then counter increments.
  - When counter==DEPTH-1 is written, next state is RUN and busy falls.
  - busy is therefore high for exactly DEPTH cycles after reset deasserts.
  - Counter wrap: counter is ADDR_W bits; the transition is decided on the terminal count, not on overflow.
- Reset mid-CLEAR restarts the clear at entry 0. Reset in RUN re-enters CLEAR.
- Writes:
  - In RUN with we=1, mem[waddr] <= wdata at the edge.
  - When ZERO_REG=1 and waddr==0, the write is discarded.
  - In CLEAR, external writes are discarded and wr_err <= 1 if we=1.
  - wr_err clears only on reset.
- Reads (per port, independent):
  - Value = 0 if busy.
  - Otherwise value = 0 if ZERO_REG and raddr==0.
  - Otherwise value = wdata if BYPASS, we, waddr==raddr and the write is not discarded.
  - Otherwise value = mem[raddr].
- REG_READ=0: rdata is combinational from that value. With BYPASS=0, a same-cycle write shows only after the edge.
- REG_READ=1: rdata updates one clock after raddr is presented. With BYPASS=1 it includes a write in that same cycle; with BYPASS=0 it returns the old data.
- Multiple read ports addressing the same entry all return an identical value.
- Simultaneous clear-write and external write: the clear always wins.
- No X may propagate on any read after busy falls.

Decomposition:
- Package regfile_pkg:
  - DEPTH derivation function.
  - Clear FSM state encoding (CLEAR=1'b0, RUN=1'b1).
  - Slice helper macros/functions for the packed port vectors.
- Sub-module regfile_clr_seq:
  - Clear counter, FSM and the busy/wr_err logic.
  - Outputs clr_we, clr_addr and busy.
  - The top level muxes clear vs. external write and generates the NREAD read ports in a generate loop.

Test Plan:
- Reset for 3 cycles, release; sample busy every cycle -> busy=1 for exactly 32 cycles, then 0. After that, all 32 entries on both ports read 0 (rdata never X).
- After the clear, write 0xDEADBEEF to entry 5, then read ports 0 and 1 both at address 5 -> both return 0xDEADBEEF (next cycle when REG_READ=1).
- ZERO_REG=1: write 0x12345678 to entry 0, then read entry 0 -> 0. Repeat with ZERO_REG=0 -> 0x12345678.
- Bypass, same cycle: we=1, waddr=7, wdata=0xA5A5A5A5 with raddr0=7 -> rdata0=0xA5A5A5A5 in that cycle (REG_READ=0) or the next cycle (REG_READ=1). With BYPASS=0 and REG_READ=0 -> old value 0 in that cycle.
- Assert we=1 (waddr=3, wdata=0xFFFF0000) in the 10th cycle of the clear:
  - wr_err rises next cycle and stays high.
  - After busy falls, entry 3 reads 0.
  - A subsequent reset clears wr_err.
- Write 0x11 to entry 31, pulse reset in the 20th cycle of a second clear -> busy stays high 32 cycles after the final release, and entry 31 reads 0.
